// File: rtl/tc_pl_cap_seq.sv
// tc_pl_cap_seq: capture sequencer stepping gain passes, streaming ADC samples to a write port with running CRC-32 and duration.
module tc_pl_cap_seq #(
    parameter int DW = 32,
    parameter int AW = 32,
    parameter int PW = 14,
    parameter int GW = 3
) (
    input  logic          clk125,
    input  logic          rst,
    input  logic          cap_trig,
    input  logic [GW-1:0] cap_gain_number,
    input  logic [31:0]   cap_gain_del,
    input  logic [PW-1:0] cap_points,
    input  logic [AW-1:0] cap_addr,
    input  logic          adc_valid,
    input  logic [DW-1:0] adc_data,
    output logic          adc_ready,
    output logic          wr_valid,
    input  logic          wr_ready,
    output logic [AW-1:0] wr_addr,
    output logic [DW-1:0] wr_data,
    output logic [1:0]    gain_sel,
    output logic          cap_cing,
    output logic          cap_cmpt,
    output logic [31:0]   cap_crc32,
    output logic [31:0]   cap_time
);
    typedef enum logic [2:0] {IDLE, SETTLE, ACQ, NEXT, DONE} state_t;
    state_t        state;
    logic [2:0]    passes;
    logic [31:0]   del;
    logic [31:0]   settle;
    logic [PW-1:0] pts;
    logic [PW-1:0] cnt;
    logic [AW-1:0] ptr;
    logic [31:0]   crc;
    logic [31:0]   tcnt;
    logic          drained;
    logic          accept;
    logic [2:0]    gain_norm;
    function automatic logic [31:0] crc_word(input logic [31:0] c, input logic [DW-1:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < DW; i++) r = (r >> 1) ^ ((r[0] ^ d[i]) ? 32'hEDB88320 : 32'h0);
        return r;
    endfunction
    assign drained   = !wr_valid || wr_ready;
    assign adc_ready = (state == ACQ) && drained;
    assign accept    = adc_valid && adc_ready;
    assign gain_norm = (32'(cap_gain_number) == 32'd0) ? 3'd1 :
                       (32'(cap_gain_number) > 32'd4) ? 3'd4 : 3'(cap_gain_number);
    always_ff @(posedge clk125) begin
        if (rst) begin
            state     <= IDLE;
            passes    <= 3'd1;
            del       <= '0;
            settle    <= '0;
            pts       <= '0;
            cnt       <= '0;
            ptr       <= '0;
            crc       <= '1;
            tcnt      <= '0;
            gain_sel  <= '0;
            wr_valid  <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            cap_cing  <= 1'b0;
            cap_cmpt  <= 1'b0;
            cap_crc32 <= '0;
            cap_time  <= '0;
        end else begin
            if (accept) begin
                wr_valid <= 1'b1;
                wr_data  <= adc_data;
                wr_addr  <= ptr;
            end else if (wr_ready) begin
                wr_valid <= 1'b0;
            end
            if ((state == SETTLE || state == ACQ || state == NEXT) && tcnt != 32'hFFFF_FFFF)
                tcnt <= tcnt + 32'd1;
            case (state)
                IDLE: if (cap_trig) begin
                    passes   <= gain_norm;
                    del      <= cap_gain_del;
                    pts      <= cap_points;
                    ptr      <= cap_addr;
                    settle   <= (cap_gain_del == 32'd0) ? 32'd1 : cap_gain_del;
                    cnt      <= '0;
                    gain_sel <= '0;
                    crc      <= '1;
                    tcnt     <= '0;
                    cap_cmpt <= 1'b0;
                    cap_cing <= 1'b1;
                    state    <= SETTLE;
                end
                SETTLE: begin
                    settle <= settle - 32'd1;
                    if (settle == 32'd1) state <= (pts == '0) ? NEXT : ACQ;
                end
                ACQ: if (accept) begin
                    ptr <= ptr + AW'(DW / 8);
                    crc <= crc_word(crc, adc_data);
                    cnt <= cnt + PW'(1);
                    if (cnt + PW'(1) == pts) state <= NEXT;
                end
                NEXT: if (drained) begin
                    if ({1'b0, gain_sel} + 3'd1 == passes) begin
                        state <= DONE;
                    end else begin
                        gain_sel <= gain_sel + 2'd1;
                        settle   <= (del == 32'd0) ? 32'd1 : del;
                        cnt      <= '0;
                        state    <= SETTLE;
                    end
                end
                DONE: begin
                    cap_crc32 <= ~crc;
                    cap_time  <= tcnt;
                    cap_cing  <= 1'b0;
                    cap_cmpt  <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/tc_pl_cap_seq.md
# tc_pl_cap_seq

Capture sequencer: the engine-side counterpart of the capture GP register block. It responds to the one-cycle `cap_trig` pulse from the control path, steps through the configured gain settings, streams ADC samples into a memory write port, and reports back `cap_cing`, `cap_cmpt`, `cap_crc32` and `cap_time`, which the GP block exposes to the PS. It sits between the GP config block and the DDR write master, in the `clk125` domain.

## Interface
Parameters:
- `DW`, 32: sample and write-data width; also the CRC word width.
- `AW`, 32: write address width.
- `PW`, 14: width of `cap_points`.
- `GW`, 3: width of `cap_gain_number`.

Ports:
- `clk125`  in  1  sole clock.
- `rst`  in  1  reset; one clock; reset is synchronous and active-high.
- `cap_trig`  in  1  start pulse, one cycle.
- `cap_gain_number`  in  GW  number of gain passes. 0 is treated as 1; values above 4 are clamped to 4.
- `cap_gain_del`  in  32  settle cycles before each pass.
- `cap_points`  in  PW  samples per pass.
- `cap_addr`  in  AW  byte base address.
- `adc_valid`  in  1  sample offered.
- `adc_data`  in  DW  sample.
- `adc_ready`  out  1  sample accepted when `adc_valid & adc_ready`.
- `wr_valid`  out  1  write word valid.
- `wr_ready`  in  1  write port accepts.
- `wr_addr`  out  AW  byte address of the word.
- `wr_data`  out  DW  word.
- `gain_sel`  out  2  index of the active gain pass, driving the relay/DAC mux.
- `cap_cing`  out  1  capture in progress.
- `cap_cmpt`  out  1  capture complete, sticky.
- `cap_crc32`  out  32  final CRC of all written words.
- `cap_time`  out  32  capture duration in cycles.

## Operation
- States: IDLE, SETTLE, ACQ, NEXT, DONE.
- **IDLE**
  - On `cap_trig`, latch `cap_gain_number` (normalised), `cap_gain_del`, `cap_points` and `cap_addr`.
  - Set address pointer = `cap_addr`, gain index = 0, CRC register = 0xFFFFFFFF, time counter = 0.
  - Clear `cap_cmpt` and set `cap_cing`, then go to SETTLE.
- **SETTLE**
  - Lasts max(`cap_gain_del`, 1) cycles, then goes to ACQ.
  - If latched points = 0, it goes to NEXT instead.
- **ACQ**
  - `adc_ready` = `!wr_valid | wr_ready`; it is 0 in every other state.
  - Each accepted sample loads the single-entry output register: `wr_data` = sample, `wr_addr` = pointer.
  - On each accepted sample, the pointer advances by DW/8 (modulo 2^AW, wrap permitted) and the CRC updates.
  - After the sample count reaches the latched points, go to NEXT.
- **NEXT**
  - Waits until `!wr_valid | wr_ready`, so the last word drains.
  - If gain index + 1 = passes, go to DONE; otherwise increment the gain index and go to SETTLE.
- **DONE** (one cycle)
  - `cap_crc32` <= ~CRC, `cap_time` <= time counter.
  - `cap_cing` <= 0, `cap_cmpt` <= 1, then go to IDLE.
- **CRC**
  - CRC-32 IEEE, reflected, polynomial 0xEDB88320, initial value 0xFFFFFFFF, final XOR 0xFFFFFFFF.
  - Each word is processed as DW/8 bytes, least-significant byte first, bit-serial LSB first; the whole word is done in one cycle.
- **Time counter**
  - Increments on every cycle spent in SETTLE, ACQ or NEXT.
  - Saturates at 0xFFFFFFFF.
- **Output register**
  - `wr_valid` is set on accept and cleared on `wr_ready` unless a new accept happens in the same cycle.
  - `wr_addr`/`wr_data` hold while `wr_valid & !wr_ready`.
- `cap_trig` is ignored outside IDLE.
- `cap_cmpt` stays high until the next accepted trigger.
- `cap_crc32` and `cap_time` hold until the next DONE.

## Timing
- Reset values: `cap_cing`=0, `cap_cmpt`=0, `cap_crc32`=0, `cap_time`=0, `wr_valid`=0, `wr_addr`=0, `wr_data`=0, `adc_ready`=0, `gain_sel`=0, state = IDLE.
- `cap_trig` at cycle T gives `cap_cing`=1 at T+1, with the first SETTLE cycle at T+1.
- Accept at cycle A gives `wr_valid`=1 with data/address at A+1.
- `gain_sel` is registered and equals the gain index; it changes on entry to SETTLE.
- `cap_cmpt` rises, and `cap_crc32`/`cap_time` update, on the same edge that `cap_cing` falls.
- `rst` mid-capture returns to reset values next edge; no DONE and no completion flag are produced, and any pending write is discarded.
- A `cap_trig` coincident with the DONE cycle is ignored, because it is not in IDLE.
- Config inputs changing during a capture have no effect.

## Test plan
- **Single zero word**: passes=1, del=5, points=1, `adc_data`=0, `adc_valid`=`wr_ready`=1, trig → exactly one write at `cap_addr` with data 0; `cap_crc32`=0x2144DF1C; `cap_time`=7 (SETTLE 5 + ACQ 1 + NEXT 1); `cap_cmpt`=1.
- **Gain stepping**: passes=4, del=0, points=3, base 0x1000 → 12 writes at addresses 0x1000..0x102C in steps of 4; `gain_sel` sequence 0,1,2,3; each pass begins with one SETTLE cycle.
- **Clamping and wrap**: `cap_gain_number`=0 → one pass; `cap_gain_number`=7 → four passes; base 0xFFFFFFFC with points=2 → addresses 0xFFFFFFFC then 0x00000000.
- **Backpressure**: `wr_ready` toggling 1010…, `adc_valid` random → no sample lost or duplicated; `wr_data`/`wr_addr` stable while stalled; CRC matches the model over the delivered words.
- **Zero points**: points=0, passes=2, del=3 → no writes; `cap_crc32`=0x00000000; `cap_time`=8.
- **Reset and re-trigger**: `rst` asserted mid-ACQ → all outputs at reset values the next cycle; `cap_trig` during a capture is ignored, with `cap_time` unchanged versus an undisturbed run; a fresh trig after reset completes normally.
